// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-32 pipeline control blocks.
package mips_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    STEP = 2'd2
  } state_t;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned DRAIN_W = 2;

  localparam logic [31:0]        NOP_INSTR = 32'h0;
  localparam logic [REG_W-1:0]   REG_ZERO  = 5'd0;
  localparam logic [DRAIN_W-1:0] DRAIN_MAX = 2'd3;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard/run-control bundle between the pipeline datapath and the hazard sequencer.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             ifid_uses_rt;
  logic             idex_memread;
  logic [4:0]       idex_rt;
  logic             pcsrc;
  logic             dbg_halt;
  logic             dbg_step;
  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             exmem_bubble;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ifid_rs, ifid_rt, ifid_uses_rt, idex_memread, idex_rt,
           pcsrc, dbg_halt, dbg_step,
    input  pc_we, ifid_we, ifid_flush, idex_bubble, exmem_bubble,
           halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  ifid_rs, ifid_rt, ifid_uses_rt, idex_memread, idex_rt,
           pcsrc, dbg_halt, dbg_step,
    output pc_we, ifid_we, ifid_flush, idex_bubble, exmem_bubble,
           halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall, taken-branch flush and debug halt/step sequencer for the 5-stage pipeline.
module pipeline_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter bit          START_HALTED = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  bus
);

  state_t               state;
  logic [DRAIN_W-1:0]   drain;

  logic load_use_c;
  logic pc_we_c;
  logic ifid_we_c;
  logic ifid_flush_c;
  logic idex_bubble_c;
  logic exmem_bubble_c;
  logic stall_inc_c;
  logic flush_inc_c;

  // Load-use: the load in EX writes a register the IF/ID instruction reads.
  assign load_use_c = bus.idex_memread
                    && (bus.idex_rt != REG_ZERO)
                    && ((bus.idex_rt == bus.ifid_rs)
                        || (bus.ifid_uses_rt && (bus.idex_rt == bus.ifid_rt)));

  // Pipeline-register controls, highest-priority condition first.
  always_comb begin
    pc_we_c        = 1'b1;
    ifid_we_c      = 1'b1;
    ifid_flush_c   = 1'b0;
    idex_bubble_c  = 1'b0;
    exmem_bubble_c = 1'b0;
    stall_inc_c    = 1'b0;
    flush_inc_c    = 1'b0;
    if (rst) begin
      pc_we_c        = 1'b0;
      ifid_we_c      = 1'b0;
      ifid_flush_c   = 1'b1;
      idex_bubble_c  = 1'b1;
      exmem_bubble_c = 1'b1;
    end else if (bus.pcsrc) begin
      ifid_flush_c   = 1'b1;
      idex_bubble_c  = 1'b1;
      exmem_bubble_c = 1'b1;
      flush_inc_c    = 1'b1;
    end else if (load_use_c && (state != HALT)) begin
      pc_we_c       = 1'b0;
      ifid_we_c     = 1'b0;
      idex_bubble_c = 1'b1;
      stall_inc_c   = 1'b1;
    end else if (state == HALT) begin
      pc_we_c       = 1'b0;
      ifid_we_c     = 1'b0;
      idex_bubble_c = 1'b1;
    end
  end

  // Run-control FSM and drain tracker; a taken branch while halted restarts the drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= START_HALTED ? HALT : RUN;
      drain <= '0;
    end else begin
      if ((state != HALT) || bus.pcsrc) begin
        drain <= '0;
      end else if (drain != DRAIN_MAX) begin
        drain <= drain + DRAIN_W'(1);
      end
      case (state)
        RUN: begin
          if (bus.dbg_halt) state <= HALT;
        end
        HALT: begin
          if (!bus.dbg_halt)     state <= RUN;
          else if (bus.dbg_step) state <= STEP;
        end
        STEP: begin
          if (!load_use_c) state <= HALT;
        end
        default: state <= RUN;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .inc   (stall_inc_c),
    .clr   (rst),
    .count (bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .inc   (flush_inc_c),
    .clr   (rst),
    .count (bus.flush_cnt)
  );

  assign bus.pc_we        = pc_we_c;
  assign bus.ifid_we      = ifid_we_c;
  assign bus.ifid_flush   = ifid_flush_c;
  assign bus.idex_bubble  = idex_bubble_c;
  assign bus.exmem_bubble = exmem_bubble_c;
  assign bus.halted       = (state == HALT) && (drain == DRAIN_MAX);

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard and run-control sequencer for the 5-stage MIPS-32 pipeline. It detects load-use hazards and generates PC/IF-ID write enables and the ID/EX bubble. It flushes the three younger stages when a branch resolves taken in MEM. It also adds a debug halt/single-step FSM and saturating stall/flush performance counters. It sits beside the forwarding unit and drives the write-enable and flush inputs of PC, IFID, IDEX and EXMEM.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter.
- START_HALTED, 0, 1: FSM leaves reset in HALT instead of RUN.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- ifid_rs  in  5  rs field of the instruction in IF/ID.
- ifid_rt  in  5  rt field of the instruction in IF/ID.
- ifid_uses_rt  in  1  IF/ID instruction reads rt (R-type, beq, sw).
- idex_memread  in  1  MemRead of the instruction in ID/EX.
- idex_rt  in  5  destination rt of the instruction in ID/EX.
- pcsrc  in  1  Branch_EXMEM & zero_EXMEM (branch taken in MEM).
- dbg_halt  in  1  level: request halt.
- dbg_step  in  1  single-cycle pulse: execute one instruction while halted.
- pc_we  out  1  PC load enable.
- ifid_we  out  1  IF/ID load enable.
- ifid_flush  out  1  load NOP (0x00000000) into IF/ID.
- idex_bubble  out  1  zero control bits entering ID/EX.
- exmem_bubble  out  1  zero control bits entering EX/MEM.
- halted  out  1  in HALT and pipeline drained.
- stall_cnt  out  CNT_W  load-use stall cycles.
- flush_cnt  out  CNT_W  taken-branch flush events.

## Operation
- load_use = idex_memread & (idex_rt != 0) & ((idex_rt == ifid_rs) | (ifid_uses_rt & idex_rt == ifid_rt)).
- FSM states are RUN, HALT and STEP.
  - Reset enters RUN, or HALT if START_HALTED=1.
  - RUN -> HALT when dbg_halt=1.
  - HALT -> STEP on dbg_step=1 while dbg_halt=1.
  - HALT -> RUN when dbg_halt=0.
  - STEP -> HALT after the first cycle with no load_use. One instruction has then been fetched and accepted.
- Output priority, highest first:
  1. rst: pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, exmem_bubble=1.
  2. pcsrc (any state): pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=1, exmem_bubble=1. The branch target is never lost while halted.
  3. load_use (RUN or STEP): pc_we=0, ifid_we=0, idex_bubble=1, other flushes 0.
  4. HALT: pc_we=0, ifid_we=0, idex_bubble=1. The IF/ID instruction is held and the pipeline drains behind it.
  5. Otherwise (RUN, or STEP without hazard): pc_we=1, ifid_we=1, all flushes 0.
- Drain counter (2 bits):
  - Cleared on reset and on any cycle not in HALT.
  - In HALT it increments, saturating at 3, on cycles without pcsrc; a pcsrc cycle clears it.
  - halted = (state==HALT) & (drain==3).
- Counters:
  - stall_cnt increments on cycles where rule 3 is selected.
  - flush_cnt increments on cycles where rule 2 is selected and rst=0.
  - Both saturate at all-ones and clear on rst.

## Timing
- Every output except halted and the counters is combinational from current inputs and state. There is zero-cycle latency to the pipeline registers.
- Registered: state, drain, stall_cnt and flush_cnt are updated at the edge ending the cycle in which the event occurred.
- A load-use stall lasts exactly one cycle; the bubble removes the condition on the next cycle.
- Taken branch: one pcsrc cycle flushes three younger instructions. Next-cycle fetch is from the target.
- dbg_step is ignored in RUN and STEP. A step arriving in the same cycle as dbg_halt deassertion goes to RUN.
- rst mid-stall or mid-step aborts the operation: state goes to its reset value and counters clear on that edge.
- After reset every output is as in rule 5 (RUN) or rule 4 (HALT). halted=0 until 3 drain cycles have elapsed.

## Structure
- The shared package mips_pkg holds:
  - the state typedef (RUN=2'd0, HALT=2'd1, STEP=2'd2);
  - NOP_INSTR = 32'h0;
  - REG_ZERO = 5'd0.
- One natural sub-module, sat_counter (parameter W, inc, clr -> count). It is instantiated twice.
- The hazard compare stays inline.

## Test plan
- lw $2,0($0) then add $3,$2,$1 -> exactly one cycle with pc_we=0, ifid_we=0, idex_bubble=1; stall_cnt 0->1. The add then gets $2 through the forwarding unit.
- lw $0,0($1) then add $3,$0,$0 -> no stall, because the rt=0 exclusion applies.
- beq taken, pcsrc=1 for one cycle -> ifid_flush, idex_bubble and exmem_bubble all 1, pc_we=1; flush_cnt=1. The three younger instructions never write registers or memory.
- dbg_halt=1 in RUN -> next cycle pc_we=0. halted=1 after 3 further cycles. A dbg_step pulse -> one cycle with pc_we=1, then halted=1 again after 3 cycles.
- Halted with a branch in MEM (pcsrc=1) -> pc_we=1 and flushes asserted, state stays HALT, drain restarts from 0.
- Load-use and pcsrc in the same cycle -> pcsrc wins: pc_we=1, stall_cnt unchanged. Assert rst during a step -> state is RUN next cycle and both counters are 0.
